// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment driver for an HH:MM:SS clock.
// Snapshots the time once per frame, converts it to BCD, inserts a dark
// cycle between digits, and blinks the field being edited in set mode.
module clock_display_scan #(
  parameter int unsigned SCAN_MS  = 2,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ms_pulse,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hr,
  input  logic       i_set_mode,
  input  logic [1:0] i_field,
  output logic [6:0] o_seg,
  output logic [5:0] o_dig,
  output logic       o_dp
);

  localparam int unsigned SCAN_W   = 8;
  localparam int unsigned BLINK_W  = 10;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned LAST_IDX = 5;
  localparam logic [6:0]  SEG_DASH = 7'b1000000;
  localparam logic [5:0]  DIG_OFF  = 6'b111111;

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic               r_adv;
  logic [IDX_W-1:0]   r_idx;
  logic               r_lit;
  logic [5:0]         r_snap_sec;
  logic [5:0]         r_snap_min;
  logic [4:0]         r_snap_hr;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase_on;
  logic               r_set_q;
  logic [1:0]         r_field_q;

  logic               w_restart;
  logic               w_phase_eff;
  logic [3:0]         w_sec_ones, w_sec_tens;
  logic [3:0]         w_min_ones, w_min_tens;
  logic [3:0]         w_hr_ones, w_hr_tens;
  logic               w_sec_bad, w_min_bad, w_hr_bad;
  logic [3:0]         w_digit;
  logic               w_bad;
  logic [1:0]         w_field;
  logic [6:0]         w_seg;
  logic               w_blank;
  logic               w_show;
  logic               w_dp;
  logic [5:0]         w_dig_en;

  // Standard active-high {g,f,e,d,c,b,a} patterns for decimal digits.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0111111;
      4'd1:    seg_of = 7'b0000110;
      4'd2:    seg_of = 7'b1011011;
      4'd3:    seg_of = 7'b1001111;
      4'd4:    seg_of = 7'b1100110;
      4'd5:    seg_of = 7'b1101101;
      4'd6:    seg_of = 7'b1111101;
      4'd7:    seg_of = 7'b0000111;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  // Per-digit dwell counter; r_adv pulses for one cycle when a digit's time is up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan_cnt <= '0;
      r_adv      <= 1'b0;
    end else begin
      r_adv <= 1'b0;
      if (i_ms_pulse) begin
        if (r_scan_cnt == SCAN_W'(SCAN_MS - 1)) begin
          r_scan_cnt <= '0;
          r_adv      <= 1'b1;
        end else begin
          r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
      end
    end
  end

  // Digit index; the time is sampled only when the frame wraps back to digit 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx      <= '0;
      r_lit      <= 1'b0;
      r_snap_sec <= '0;
      r_snap_min <= '0;
      r_snap_hr  <= '0;
    end else if (r_adv) begin
      r_lit <= 1'b1;
      if (r_idx == IDX_W'(LAST_IDX)) begin
        r_idx      <= '0;
        r_snap_sec <= i_sec;
        r_snap_min <= i_min;
        r_snap_hr  <= i_hr;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // A newly selected field restarts the blink visible, so the user sees it at once.
  assign w_restart   = (i_set_mode & ~r_set_q) | (i_field != r_field_q);
  assign w_phase_eff = r_phase_on | w_restart;

  // Blink half-period counter and phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
      r_set_q     <= 1'b0;
      r_field_q   <= '0;
    end else begin
      r_set_q   <= i_set_mode;
      r_field_q <= i_field;
      if (w_restart) begin
        r_blink_cnt <= '0;
        r_phase_on  <= 1'b1;
      end else if (i_ms_pulse) begin
        if (r_blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
          r_blink_cnt <= '0;
          r_phase_on  <= ~r_phase_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // Binary-to-BCD split of the snapshot plus range checks.
  assign w_sec_tens = 4'(r_snap_sec / 6'd10);
  assign w_sec_ones = 4'(r_snap_sec % 6'd10);
  assign w_min_tens = 4'(r_snap_min / 6'd10);
  assign w_min_ones = 4'(r_snap_min % 6'd10);
  assign w_hr_tens  = 4'(r_snap_hr / 5'd10);
  assign w_hr_ones  = 4'(r_snap_hr % 5'd10);
  assign w_sec_bad  = r_snap_sec > 6'd59;
  assign w_min_bad  = r_snap_min > 6'd59;
  assign w_hr_bad   = r_snap_hr > 5'd23;

  // Select the current digit's value, validity and owning field.
  always_comb begin
    w_digit = '0;
    w_bad   = 1'b0;
    w_field = 2'd0;
    case (r_idx)
      3'd0: begin w_digit = w_sec_ones; w_bad = w_sec_bad; w_field = 2'd1; end
      3'd1: begin w_digit = w_sec_tens; w_bad = w_sec_bad; w_field = 2'd1; end
      3'd2: begin w_digit = w_min_ones; w_bad = w_min_bad; w_field = 2'd2; end
      3'd3: begin w_digit = w_min_tens; w_bad = w_min_bad; w_field = 2'd2; end
      3'd4: begin w_digit = w_hr_ones;  w_bad = w_hr_bad;  w_field = 2'd3; end
      3'd5: begin w_digit = w_hr_tens;  w_bad = w_hr_bad;  w_field = 2'd3; end
      default: ;
    endcase
  end

  assign w_seg    = w_bad ? SEG_DASH : seg_of(w_digit);
  assign w_blank  = i_set_mode && (i_field != 2'd0) && !w_phase_eff && (i_field == w_field);
  assign w_show   = r_lit && !r_adv && !w_blank;
  assign w_dp     = w_show && ((r_idx == 3'd2) || (r_idx == 3'd4)) && !r_snap_sec[0];
  assign w_dig_en = ~(6'b000001 << r_idx);

  // Output register; the cycle of r_adv becomes the all-dark anti-ghost gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dig <= DIG_OFF;
      o_seg <= '0;
      o_dp  <= 1'b0;
    end else begin
      o_dig <= w_show ? w_dig_en : DIG_OFF;
      o_seg <= r_lit ? w_seg : '0;
      o_dp  <= w_dp;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: directed scenarios plus a randomized stretch,
// every cycle compared with a counting model of frames, snapshots and blink.
module tb_clock_display_scan;

  localparam int SCAN_MS  = 2;
  localparam int BLINK_MS = 4;

  logic       clk;
  logic       rst;
  logic       ms;
  logic [5:0] sec;
  logic [5:0] min_v;
  logic [4:0] hr;
  logic       set_mode;
  logic [1:0] field;
  logic [6:0] seg;
  logic [5:0] dig;
  logic       dp;

  clock_display_scan #(.SCAN_MS(SCAN_MS), .BLINK_MS(BLINK_MS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ms_pulse (ms),
    .i_sec      (sec),
    .i_min      (min_v),
    .i_hr       (hr),
    .i_set_mode (set_mode),
    .i_field    (field),
    .o_seg      (seg),
    .o_dig      (dig),
    .o_dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int e_cnt    = 0;

  // Model: total pulses, advances so far, edge of latest advance, pulses since blink restart.
  int m_tot, m_adv, m_adv_edge, m_ps, m_sec, m_min, m_hr;
  logic       m_prev_set;
  logic [1:0] m_prev_field;

  typedef struct packed {
    logic [5:0] dig;
    logic [6:0] seg;
  } lit_t;
  lit_t lit_q[$];
  logic [5:0] prev_dig = 6'h3F;
  int t1_digits[6] = '{6, 5, 4, 3, 2, 1};

  function automatic logic [6:0] seg_enc(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int idx);
    int v;
    int lim;
    v   = (idx < 2) ? m_sec : (idx < 4) ? m_min : m_hr;
    lim = (idx < 4) ? 59 : 23;
    if (v > lim) return 7'b1000000;
    return seg_enc((idx % 2 == 0) ? (v % 10) : (v / 10));
  endfunction

  task automatic model_reset();
    m_tot = 0; m_adv = 0; m_adv_edge = -100; m_ps = 0;
    m_sec = 0; m_min = 0; m_hr = 0;
    m_prev_set = 1'b0; m_prev_field = 2'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict outputs from pre-edge model state, advance the model, compare.
  task automatic step();
    logic [5:0] exp_dig;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       chk_seg;
    bit         restart, dark, blank, lit;
    int         idx;
    @(posedge clk);
    e_cnt++;
    if (rst) begin
      model_reset();
      exp_dig = 6'h3F; exp_seg = 7'd0; exp_dp = 1'b0; chk_seg = 1'b1;
    end else begin
      restart = (set_mode && !m_prev_set) || (field != m_prev_field);
      idx     = m_adv % 6;
      dark    = (m_adv == 0) || (m_adv_edge == e_cnt - 1);
      blank   = set_mode && (field != 2'd0) && !restart &&
                ((m_ps / BLINK_MS) % 2 == 1) && (idx / 2 + 1 == int'(field));
      lit     = !dark && !blank;
      exp_dig = lit ? ~(6'b000001 << idx) : 6'h3F;
      exp_dp  = lit && (idx == 2 || idx == 4) && (m_sec % 2 == 0);
      exp_seg = (m_adv == 0) ? 7'd0 : model_seg(idx);
      chk_seg = lit || (m_adv == 0);
      if (m_adv_edge == e_cnt - 1 && m_adv % 6 == 0) begin
        m_sec = int'(sec); m_min = int'(min_v); m_hr = int'(hr);
      end
      if (ms) begin
        m_tot++;
        if (m_tot % SCAN_MS == 0) begin
          m_adv++;
          m_adv_edge = e_cnt;
        end
      end
      if (restart) m_ps = 0;
      else if (ms) m_ps++;
      m_prev_set   = set_mode;
      m_prev_field = field;
    end
    #1;
    check($sformatf("dig@%0d", e_cnt), 32'(dig), 32'(exp_dig));
    check($sformatf("dp@%0d", e_cnt), 32'(dp), 32'(exp_dp));
    if (chk_seg) check($sformatf("seg@%0d", e_cnt), 32'(seg), 32'(exp_seg));
    if (dig !== 6'h3F && prev_dig === 6'h3F) lit_q.push_back('{dig: dig, seg: seg});
    prev_dig = dig;
  endtask

  task automatic ms_tick(input int gap);
    ms = 1'b1;
    step();
    ms = 1'b0;
    repeat (gap) step();
  endtask

  // Pulse every third cycle until digit di is lit (bounded).
  task automatic wait_dig(input int di);
    logic [5:0] want;
    bit ok;
    want = ~(6'b000001 << di);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ms = (i % 3 == 0);
      step();
      ms = 1'b0;
      if (dig === want) ok = 1'b1;
    end
    check($sformatf("wait_dig%0d", di), 32'(ok), 32'd1);
  endtask

  task automatic check_lit(input string tag, input int k, input int di, input logic [6:0] exp_seg);
    logic [5:0] ed;
    ed = ~(6'b000001 << di);
    if (k < lit_q.size()) begin
      check($sformatf("%s%0d_dig", tag, k), 32'(lit_q[k].dig), 32'(ed));
      check($sformatf("%s%0d_seg", tag, k), 32'(lit_q[k].seg), 32'(exp_seg));
    end else begin
      check($sformatf("%s%0d_missing", tag, k), 32'(lit_q.size()), 32'(k + 1));
    end
  endtask

  initial begin
    bit ok;
    model_reset();
    rst = 1'b1; ms = 1'b0; set_mode = 1'b0; field = 2'd0;
    sec = 6'd56; min_v = 6'd34; hr = 5'd12;
    repeat (3) step();
    rst = 1'b0;
    lit_q.delete();

    // First frame shows the zero snapshot; the wrap loads 12:34:56.
    repeat (22) ms_tick(2);
    for (int k = 0; k < 5; k++) check_lit("frame0_", k, k + 1, seg_enc(0));
    for (int k = 0; k < 6; k++) check_lit("frame1_", k + 5, k, seg_enc(t1_digits[k]));

    // Mid-frame input change stays hidden until the next wrap.
    wait_dig(3);
    sec = 6'd57;
    lit_q.delete();
    repeat (12) ms_tick(2);
    check_lit("midchg_", 0, 4, seg_enc(2));
    check_lit("midchg_", 1, 5, seg_enc(1));
    check_lit("midchg_", 2, 0, seg_enc(7));
    check_lit("midchg_", 3, 1, seg_enc(5));

    // Out-of-range seconds and hours show dashes.
    sec = 6'd60; hr = 5'd24;
    repeat (24) ms_tick(2);
    wait_dig(0); check("bad_sec_ones", 32'(seg), 32'(7'b1000000));
    wait_dig(1); check("bad_sec_tens", 32'(seg), 32'(7'b1000000));
    wait_dig(2); check("min_ones",     32'(seg), 32'(seg_enc(4)));
    wait_dig(3); check("min_tens",     32'(seg), 32'(seg_enc(3)));
    wait_dig(4); check("bad_hr_ones",  32'(seg), 32'(7'b1000000));
    wait_dig(5); check("bad_hr_tens",  32'(seg), 32'(7'b1000000));

    // Blink the minutes, then move the edit to hours while blanked.
    sec = 6'd56; hr = 5'd12;
    set_mode = 1'b1; field = 2'd2;
    repeat (40) ms_tick(2);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      ms_tick(2);
      if ((m_ps / BLINK_MS) % 2 == 1) ok = 1'b1;
    end
    check("blink_off_reached", 32'(ok), 32'd1);
    field = 2'd3;
    repeat (40) ms_tick(2);

    // Randomized time, mode, field and pulse spacing.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        sec   = 6'($urandom_range(0, 63));
        min_v = 6'($urandom_range(0, 63));
        hr    = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 15) == 0) set_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) field = 2'($urandom_range(0, 3));
      ms_tick($urandom_range(1, 4));
    end

    // Asynchronous reset in the middle of a frame.
    set_mode = 1'b0; field = 2'd0;
    sec = 6'd56; min_v = 6'd34; hr = 5'd12;
    repeat (12) ms_tick(2);
    wait_dig(4);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_dig", 32'(dig), 32'(6'h3F));
    check("rst_async_seg", 32'(seg), 32'd0);
    check("rst_async_dp",  32'(dp),  32'd0);
    step();
    rst = 1'b0;
    prev_dig = 6'h3F;
    lit_q.delete();
    repeat (3) ms_tick(2);
    check_lit("post_rst_", 0, 1, seg_enc(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream consumer of the clock module's o_sec/o_min/o_hr binary time outputs.
- Drives a 6-digit multiplexed 7-segment display (HH MM SS) with per-frame snapshot, binary-to-BCD conversion, anti-ghost blanking, and blinking of the field being edited in set mode.
- Shares the 1 ms pulse that feeds the clock module's ClockControl.

Parameters:
SCAN_MS, 2, ms pulses each digit stays lit before advancing (range 1..255)
BLINK_MS, 250, ms pulses per blink half-period (range 1..1023)

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_ms_pulse  input  1  one-cycle pulse every 1 ms
i_sec  input  6  seconds, binary, legal 0..59
i_min  input  6  minutes, binary, legal 0..59
i_hr  input  5  hours, binary, legal 0..23
i_set_mode  input  1  high while the clock is in set mode
i_field  input  2  field under edit: 0 none, 1 sec, 2 min, 3 hr
o_seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-high
o_dig  output  6  digit enables, active-low; bit0 = sec ones ... bit5 = hr tens
o_dp  output  1  decimal point / colon, active-high

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_dig=6'b111111, o_seg=0, o_dp=0, digit index=0, scan count=0, blink count=0, blink phase=ON, snapshot sec/min/hr=0.
- Scan counter:
  - Increments on each i_ms_pulse.
  - When it reaches SCAN_MS-1 and another pulse arrives, it clears and raises advance.
- Advance sequence, with the advance pulse at cycle N:
  - Cycle N+1: o_dig=6'b111111 (dead cycle, anti-ghost); index = (index==5) ? 0 : index+1.
  - Cycle N+2: o_dig drives the new digit low; o_seg and o_dp reflect the new digit.
- Snapshot: i_sec/i_min/i_hr are captured into snapshot registers only on the advance that wraps the index from 5 to 0. All six digits of a frame therefore come from one coherent time. Input changes mid-frame are invisible until the next frame.
- BCD conversion:
  - tens = value/10, ones = value%10, computed combinationally from the snapshot.
  - Sec or min >59, or hr >23: both digits of that field show a dash (o_seg=7'b1000000).
  - No leading-zero blanking; 24 h format, hr 0 shows "00".
- Segment encoding: standard 0-9 patterns, for example 0=7'b0111111, 1=7'b0000110, 8=7'b1111111.
- o_dp is high only while digit 2 (min ones) or digit 4 (hr ones) is lit AND snapshot sec is even (1 Hz colon blink).
- Blink counter:
  - Increments on i_ms_pulse.
  - At BLINK_MS-1 plus one pulse it clears and toggles the blink phase.
  - Counter clears and phase forces ON in the cycle after i_set_mode rises or i_field changes, so the edited field is visible immediately.
- Field blanking: when i_set_mode=1, i_field!=0, and phase=OFF, both digits of the selected field are suppressed:
  - o_dig stays all-high during their scan slots.
  - The index still advances normally.
  - o_dp is also suppressed for those digits.
- i_set_mode=0 or i_field=0: no blanking.
- Simultaneous events: a scan advance and a blink toggle on the same i_ms_pulse are independent; both take effect. A snapshot wrap coinciding with a field change: the snapshot still captures and the blink state still restarts.
- i_ms_pulse held high for more than one cycle counts once per cycle (caller guarantees single-cycle pulses).
- Reset mid-scan: all state returns to reset values asynchronously. The first digit lights at SCAN_MS pulses after reset release plus 2 cycles, and it is digit 1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then time 12:34:56 held, SCAN_MS=2: after 6 advances, frame wraps and snapshot loads; the next frame shows o_dig lows in order bit0..bit5 with o_seg = 6,5,4,3,2,1. Every digit change is preceded by exactly one all-high o_dig cycle.
- Change inputs from 12:34:56 to 12:34:57 while index=3: the remaining digits of the current frame still show 56 in sec; the next frame shows 57.
- i_sec=60, i_hr=24 (illegal): digits 0,1,4,5 show 7'b1000000; min digits show normally.
- i_set_mode=1, i_field=2, BLINK_MS=4: min digits are lit for 4 ms, dark (o_dig bits 2,3 never low) for 4 ms, repeating. Sec and hr digits are unaffected.
- While in phase OFF, switch i_field 2->3: min digits reappear, and hr digits stay lit for a full BLINK_MS before first blanking.
- Assert i_rst for 1 cycle mid-frame at index 4: o_dig=6'b111111 and o_seg=0 immediately. After release, digit 1 is the first lit digit, showing snapshot 0 ("0").
